// File: rtl/dsm_pkg.sv
// Shared constants for the runtime-configurable MASH modulator: order codes,
// LFSR taps/seed and the bounds of the noise-cancelled carry sum.
package dsm_pkg;

  localparam logic [1:0] ORD1 = 2'b01;
  localparam logic [1:0] ORD2 = 2'b10;
  localparam logic [1:0] ORD3 = 2'b11;

  // Right-shifting Fibonacci form of taps 16,14,13,11: feedback from bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS         = 16'h002D;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  localparam int Y_MIN = -3;
  localparam int Y_MAX = 4;

  // Bit k set means accumulator stage k+1 takes part for this order select.
  function automatic logic [2:0] stage_active(input logic [1:0] sel);
    case (sel)
      ORD3:    return 3'b111;
      ORD2:    return 3'b011;
      ORD1:    return 3'b001;
      default: return 3'b001;
    endcase
  endfunction

endpackage

// File: rtl/dsm_acc_stage.sv
// One FRAC_W-bit accumulator with carry out; sum/cout are combinational from the
// current state, the state advances on en and clr has priority over en.
module dsm_acc_stage #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] add,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W-1:0] acc_q, acc_d;
  logic [W:0]   s;

  always_comb begin
    s     = {1'b0, acc_q} + {1'b0, add} + {{W{1'b0}}, cin};
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = s[W-1:0];
    end
  end

  assign sum  = s[W-1:0];
  assign cout = s[W];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/mash_dsm_param.sv
// MASH 1/2/3 delta-sigma modulator with load handshake, LSB dither and output clamp.
// Output registered one cycle after each enabled edge; in_ready is high whenever out of reset.
module mash_dsm_param
  import dsm_pkg::*;
#(
  parameter int          INT_W       = 4,
  parameter int          FRAC_W      = 16,
  parameter int          OUT_W       = 4,
  parameter bit          CLR_ON_LOAD = 1'b1,
  parameter logic [15:0] LFSR_SEED   = LFSR_SEED_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        order_sel,
  input  logic              dither_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INT_W-1:0]  in_i,
  input  logic [FRAC_W-1:0] in_f,
  output logic [OUT_W-1:0]  out,
  output logic              out_valid,
  output logic              sat
);

  localparam int RW      = INT_W + 2;
  localparam int OUT_MAX = (1 << OUT_W) - 1;

  logic [INT_W-1:0]  shadow_i_q, shadow_i_d;
  logic [FRAC_W-1:0] shadow_f_q, shadow_f_d;
  logic              c2d1_q, c2d1_d, c3d1_q, c3d1_d, c3d2_q, c3d2_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic              sat_q, sat_d, out_valid_q, out_valid_d;

  logic              load, clr, d;
  logic [2:0]        act;
  logic [FRAC_W-1:0] s1, s2, s3_unused;
  logic              c1, c2_raw, c3_raw, c2, c3;
  logic signed [3:0]    y;
  logic signed [RW-1:0] r;
  logic signed [31:0]   r_ext;

  assign in_ready = ~rst;
  assign load     = in_valid & in_ready;
  assign clr      = load & CLR_ON_LOAD;
  assign act      = stage_active(order_sel);
  assign d        = dither_en & lfsr_q[0];

  dsm_acc_stage #(.W(FRAC_W)) u_stage1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr | ~act[0]),
    .add(shadow_f_q), .cin(d), .sum(s1), .cout(c1)
  );
  dsm_acc_stage #(.W(FRAC_W)) u_stage2 (
    .clk(clk), .rst(rst), .en(en), .clr(clr | ~act[1]),
    .add(s1), .cin(1'b0), .sum(s2), .cout(c2_raw)
  );
  dsm_acc_stage #(.W(FRAC_W)) u_stage3 (
    .clk(clk), .rst(rst), .en(en), .clr(clr | ~act[2]),
    .add(s2), .cin(1'b0), .sum(s3_unused), .cout(c3_raw)
  );

  assign c2 = c2_raw & act[1];
  assign c3 = c3_raw & act[2];

  assign y = $signed({3'b000, c1})
           + $signed({3'b000, c2}) - $signed({3'b000, c2d1_q})
           + $signed({3'b000, c3}) - $signed({2'b00, c3d1_q, 1'b0}) + $signed({3'b000, c3d2_q});
  assign r     = $signed({2'b00, shadow_i_q}) + $signed({{(RW-4){y[3]}}, y});
  assign r_ext = {{(32-RW){r[RW-1]}}, r};

  always_comb begin
    shadow_i_d  = shadow_i_q;
    shadow_f_d  = shadow_f_q;
    c2d1_d      = c2d1_q;
    c3d1_d      = c3d1_q;
    c3d2_d      = c3d2_q;
    cnt_d       = cnt_q;
    lfsr_d      = lfsr_q;
    out_d       = out_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    if (en) begin
      c2d1_d      = c2;
      c3d1_d      = c3;
      c3d2_d      = c3d1_q;
      lfsr_d      = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
      out_valid_d = (cnt_q == 2'd3);
      if (cnt_q != 2'd3) cnt_d = cnt_q + 2'd1;
      if (r_ext < 0) begin
        out_d = '0;
        sat_d = 1'b1;
      end else if (r_ext > OUT_MAX) begin
        out_d = '1;
        sat_d = 1'b1;
      end else begin
        out_d = r_ext[OUT_W-1:0];
        sat_d = 1'b0;
      end
    end
    // Delay lines of stages outside the selected order stay zeroed.
    if (!act[1]) c2d1_d = 1'b0;
    if (!act[2]) begin
      c3d1_d = 1'b0;
      c3d2_d = 1'b0;
    end
    if (load) begin
      shadow_i_d = in_i;
      shadow_f_d = in_f;
    end
    if (clr) begin
      c2d1_d      = 1'b0;
      c3d1_d      = 1'b0;
      c3d2_d      = 1'b0;
      cnt_d       = 2'd0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_i_q  <= '0;
      shadow_f_q  <= '0;
      c2d1_q      <= 1'b0;
      c3d1_q      <= 1'b0;
      c3d2_q      <= 1'b0;
      cnt_q       <= 2'd0;
      lfsr_q      <= LFSR_SEED;
      out_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      shadow_i_q  <= shadow_i_d;
      shadow_f_q  <= shadow_f_d;
      c2d1_q      <= c2d1_d;
      c3d1_q      <= c3d1_d;
      c3d2_q      <= c3d2_d;
      cnt_q       <= cnt_d;
      lfsr_q      <= lfsr_d;
      out_q       <= out_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign sat       = sat_q;
  assign out_valid = out_valid_q;

  assert property (@(posedge clk) disable iff (rst) (y >= Y_MIN) && (y <= Y_MAX));

endmodule

// File: tb/tb_mash_dsm_param.sv
// Bench for mash_dsm_param: an arithmetic reference model checked every cycle,
// plus hand-computed sequences for warm-up, order 1, dither and reload.
module tb_mash_dsm_param;

  logic        clk = 1'b0;
  logic        rst, en, dither_en, in_valid;
  logic [1:0]  order_sel;
  logic [3:0]  in_i;
  logic [15:0] in_f;
  logic        in_ready, out_valid, sat;
  logic [3:0]  out;

  int n_pass = 0;
  int n_checks = 0;

  mash_dsm_param #(
    .INT_W(4), .FRAC_W(16), .OUT_W(4), .CLR_ON_LOAD(1'b1), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .order_sel(order_sel), .dither_en(dither_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_i(in_i), .in_f(in_f),
    .out(out), .out_valid(out_valid), .sat(sat)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", name, got, exp);
    else n_pass++;
  endfunction

  function automatic void check_near(input string name, input longint got, input real exp, input real tol);
    real diff;
    n_checks++;
    diff = real'(got) - exp;
    if (diff > tol || diff < -tol) $display("FAIL %s: sum %0d expected %0f +/- %0f", name, got, exp, tol);
    else n_pass++;
  endfunction

  // Reference model: integer accumulators modulo 2^16 and a carry history.
  bit          m_started = 0;
  int          m_a1, m_a2, m_a3, m_h2, m_h3a, m_h3b, m_cnt, m_out, m_si, m_sf;
  bit          m_vld, m_sat;
  int unsigned m_lfsr;

  task automatic model_step();
    int ord, dd, s, c1, c2, c3, y, r, fb;
    ord = (order_sel == 2'b11) ? 3 : (order_sel == 2'b10) ? 2 : 1;
    if (rst) begin
      m_a1 = 0; m_a2 = 0; m_a3 = 0; m_h2 = 0; m_h3a = 0; m_h3b = 0;
      m_cnt = 0; m_out = 0; m_si = 0; m_sf = 0; m_vld = 0; m_sat = 0;
      m_lfsr = 32'hACE1;
      m_started = 1;
      return;
    end
    if (en) begin
      dd = dither_en ? int'(m_lfsr % 2) : 0;
      s = m_a1 + m_sf + dd; c1 = s / 65536; m_a1 = s % 65536;
      c2 = 0; c3 = 0;
      if (ord >= 2) begin s = m_a2 + m_a1; c2 = s / 65536; m_a2 = s % 65536; end
      if (ord == 3) begin s = m_a3 + m_a2; c3 = s / 65536; m_a3 = s % 65536; end
      y = c1 + (c2 - m_h2) + (c3 - 2 * m_h3a + m_h3b);
      r = m_si + y;
      m_sat = (r < 0) || (r > 15);
      m_out = (r < 0) ? 0 : (r > 15) ? 15 : r;
      m_vld = (m_cnt == 3);
      if (m_cnt < 3) m_cnt++;
      m_h3b = m_h3a; m_h3a = c3; m_h2 = c2;
      fb = int'(((m_lfsr) ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) % 2);
      m_lfsr = (m_lfsr / 2) + (fb * 32768);
    end
    if (ord < 2) begin m_a2 = 0; m_h2 = 0; end
    if (ord < 3) begin m_a3 = 0; m_h3a = 0; m_h3b = 0; end
    if (in_valid) begin
      m_si = in_i; m_sf = in_f;
      m_a1 = 0; m_a2 = 0; m_a3 = 0; m_h2 = 0; m_h3a = 0; m_h3b = 0;
      m_cnt = 0; m_vld = 0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_started)
      check("cycle_vs_model", {26'd0, out_valid, sat, out}, {26'd0, m_vld, m_sat, m_out[3:0]});
  end

  task automatic load(input int ii, input int ff, input logic [1:0] ord, input logic e);
    in_i = 4'(ii); in_f = 16'(ff); order_sel = ord; en = e; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run(input int n, output longint sum, output int satc);
    sum = 0; satc = 0;
    repeat (n) begin
      @(negedge clk);
      sum += out;
      satc += sat;
    end
  endtask

  int          ci[3] = '{5, 9, 5};
  int          cf[3] = '{12345, 50000, 12345};
  logic [1:0]  co[3] = '{2'b11, 2'b11, 2'b10};
  int          dith_seq[4] = '{5, 4, 5, 5};
  longint      sum;
  int          satc, bad;
  logic [5:0]  frozen;

  initial begin
    rst = 1'b1; en = 1'b1; in_valid = 1'b1; in_i = 4'd9; in_f = 16'd5;
    order_sel = 2'b11; dither_en = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_out", out, 0);
    check("reset_sat", sat, 0);
    check("reset_vld", out_valid, 0);
    check("reset_in_ready", in_ready, 0);

    // Order 3, integer input: constant output and 4-edge warm-up.
    rst = 1'b0; en = 1'b0; in_valid = 1'b1; in_i = 4'd3; in_f = 16'd0;
    @(negedge clk);
    in_valid = 1'b0;
    check("in_ready_run", in_ready, 1);
    en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("warmup_vld", out_valid, (k == 4) ? 1 : 0);
      if (k == 1) check("int_first_out", out, 3);
    end
    bad = 0; satc = 0;
    repeat (5000) begin
      @(negedge clk);
      if (out_valid && out != 4'd3) bad++;
      satc += sat;
    end
    check("int_out_errors", bad, 0);
    check("int_sat_count", satc, 0);

    // Order 1, half LSB: strict 7/8 alternation.
    load(7, 'h8000, 2'b01, 1'b1);
    sum = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (i < 4) check("ord1_seq", out, (i % 2 == 0) ? 7 : 8);
      sum += out;
    end
    check("ord1_sum", 32'(sum), 37500);

    // Long-run average for order 3 and order 2.
    for (int c = 0; c < 3; c++) begin
      load(ci[c], cf[c], co[c], 1'b1);
      run(16384, sum, satc);
      check_near("mean_sum", sum, 16384.0 * ci[c] + 16384.0 * cf[c] / 65536.0, 3.0);
    end

    // Saturation at both rails.
    load(15, 'hFFFF, 2'b11, 1'b1);
    run(2000, sum, satc);
    check("sat_high_seen", (satc > 0) ? 1 : 0, 1);
    load(0, 1, 2'b11, 1'b1);
    run(2000, sum, satc);
    check("sat_low_seen", (satc > 0) ? 1 : 0, 1);

    // Enable hold freezes outputs; a load is accepted with en low.
    load(5, 12345, 2'b11, 1'b1);
    repeat (100) @(negedge clk);
    check("pre_hold_vld", out_valid, 1);
    en = 1'b0;
    frozen = {m_vld, m_sat, m_out[3:0]};
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if ({out_valid, sat, out} !== frozen) bad++;
    end
    check("hold_frozen", bad, 0);
    en = 1'b1;
    repeat (50) @(negedge clk);
    load(8, 32000, 2'b11, 1'b0);
    check("load_en0_vld", out_valid, 0);
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    check("load_en0_out", out, 8);

    // Clearing reload while running restarts warm-up.
    repeat (20) @(negedge clk);
    check("pre_reload_vld", out_valid, 1);
    load(8, 32000, 2'b11, 1'b1);
    check("reload_vld_drop", out_valid, 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("reload_warmup", out_valid, (k == 4) ? 1 : 0);
    end

    // Mid-run reset, then dither from the reseeded LFSR.
    repeat (30) @(negedge clk);
    rst = 1'b1; en = 1'b1; in_valid = 1'b1; in_i = 4'd15; in_f = 16'hFFFF;
    @(negedge clk);
    check("rst_out", out, 0);
    check("rst_sat", sat, 0);
    check("rst_vld", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0; en = 1'b0; in_i = 4'd4; in_f = 16'hFFFF; order_sel = 2'b01; dither_en = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("dither_seq", out, dith_seq[k]);
    end
    order_sel = 2'b11;
    repeat (3000) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
